text_glyph_row_fetch: RTL and testbench

- Parametrised successor to the text-mode character ROM.
- Instead of returning a whole packed glyph per character, stores the font as GLYPH_H rows of GLYPH_W bits per character and returns one addressed pixel row per request.
- Requests flow through a stallable 2-stage valid/ready pipeline, with attribute post-processing (invert, underline, blank), out-of-range substitution and a saturating fault counter.
- Sits between the VGA text scanout controller and the pixel serialiser.

---
 rtl/text_glyph_row_fetch.sv | 147 ++++++++++++++
 tb/tb_text_glyph_row_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_glyph_row_fetch.sv
// Glyph row fetch: a code and row go in, one attribute-processed pixel row comes out.
// Two-stage valid/ready pipeline: ROM read plus flag capture, then attribute shaping.
module text_glyph_row_fetch #(
   parameter int CHAR_COUNT       = 27,
   parameter int GLYPH_W          = 8,
   parameter int GLYPH_H          = 16,
   parameter int CODE_W           = 8,
   parameter int REPLACEMENT_CHAR = 0,
   parameter int LSB_FIRST        = 0,
   parameter     MEMFILELOC       = ""
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CODE_W-1:0]          in_code,
   input  logic [$clog2(GLYPH_H)-1:0] in_row,
   input  logic [2:0]                 in_attr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [GLYPH_W-1:0]         out_pixels,
   output logic                       out_oob,
   output logic [7:0]                 oob_count
);

   localparam int DEPTH  = CHAR_COUNT * GLYPH_H;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int IDX_W  = (CHAR_COUNT > 1) ? $clog2(CHAR_COUNT) : 1;
   localparam int ROW_W  = $clog2(GLYPH_H);

   localparam int ATTR_INVERT    = 0;
   localparam int ATTR_UNDERLINE = 1;
   localparam int ATTR_BLANK     = 2;

   logic [GLYPH_W-1:0] rom [DEPTH];

   logic               ce;
   logic               accept;
   logic               code_oob;
   logic               row_oob;
   logic [IDX_W-1:0]   idx;
   logic [ROW_W-1:0]   row_safe;
   logic [ADDR_W-1:0]  rd_addr;

   logic               s1_valid_reg;
   logic [2:0]         s1_attr_reg;
   logic               s1_code_oob_reg;
   logic               s1_row_oob_reg;
   logic               s1_last_row_reg;
   logic [GLYPH_W-1:0] rom_data_reg;

   logic               out_valid_reg;
   logic [GLYPH_W-1:0] out_pixels_reg;
   logic               out_oob_reg;
   logic [7:0]         oob_count_reg;

   logic [GLYPH_W-1:0] shaped_next;
   logic [GLYPH_W-1:0] pixels_next;

   // in_ready depends only on the output register state, never on in_valid
   assign ce       = !out_valid_reg || out_ready;
   assign in_ready = ce;
   assign accept   = ce && in_valid;

   assign code_oob = 32'(in_code) >= 32'(CHAR_COUNT);
   assign idx      = code_oob ? IDX_W'(REPLACEMENT_CHAR) : in_code[IDX_W-1:0];

   generate
      if ((1 << ROW_W) == GLYPH_H) begin : g_row_pow2
         assign row_oob = 1'b0;
      end else begin : g_row_npow2
         assign row_oob = 32'(in_row) >= 32'(GLYPH_H);
      end
   endgenerate

   // An out-of-range row is forced to 0 so the read stays inside the array
   assign row_safe = row_oob ? '0 : in_row;
   assign rd_addr  = ADDR_W'(idx) * ADDR_W'(GLYPH_H) + ADDR_W'(row_safe);

   always_ff @(posedge clk) begin
      if (accept) rom_data_reg <= rom[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg    <= 1'b0;
         s1_attr_reg     <= '0;
         s1_code_oob_reg <= 1'b0;
         s1_row_oob_reg  <= 1'b0;
         s1_last_row_reg <= 1'b0;
      end else if (ce) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_attr_reg     <= in_attr;
            s1_code_oob_reg <= code_oob;
            s1_row_oob_reg  <= row_oob;
            s1_last_row_reg <= 32'(in_row) == 32'(GLYPH_H - 1);
         end
      end
   end

   always_comb begin
      shaped_next = rom_data_reg;
      if (s1_row_oob_reg)                               shaped_next = '0;
      if (s1_attr_reg[ATTR_INVERT])                     shaped_next = ~shaped_next;
      if (s1_attr_reg[ATTR_UNDERLINE] && s1_last_row_reg) shaped_next = '1;
      if (s1_attr_reg[ATTR_BLANK])                      shaped_next = '0;
   end

   generate
      for (genvar gi = 0; gi < GLYPH_W; gi++) begin : g_order
         if (LSB_FIRST != 0) begin : g_rev
            assign pixels_next[gi] = shaped_next[GLYPH_W-1-gi];
         end else begin : g_fwd
            assign pixels_next[gi] = shaped_next[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg  <= 1'b0;
         out_pixels_reg <= '0;
         out_oob_reg    <= 1'b0;
      end else if (ce) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            out_pixels_reg <= pixels_next;
            out_oob_reg    <= s1_code_oob_reg || s1_row_oob_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oob_count_reg <= '0;
      end else if (accept && (code_oob || row_oob) && (oob_count_reg != 8'hFF)) begin
         oob_count_reg <= oob_count_reg + 8'd1;
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_pixels = out_pixels_reg;
   assign out_oob    = out_oob_reg;
   assign oob_count  = oob_count_reg;

endmodule

// File: tb/tb_text_glyph_row_fetch.sv
// Directed bench for text_glyph_row_fetch; ROM word k is preloaded with k[7:0].
// A second instance with LSB_FIRST=1 shares all inputs.
module tb_text_glyph_row_fetch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_code;
   logic [3:0] in_row;
   logic [2:0] in_attr;
   logic       out_ready;

   logic       in_ready, out_valid, out_oob;
   logic [7:0] out_pixels, oob_count;
   logic       l_in_ready, l_out_valid, l_out_oob;
   logic [7:0] l_out_pixels, l_oob_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   text_glyph_row_fetch #(.LSB_FIRST(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_row(in_row), .in_attr(in_attr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels),
      .out_oob(out_oob), .oob_count(oob_count)
   );

   text_glyph_row_fetch #(.LSB_FIRST(1)) dut_l (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
      .in_code(in_code), .in_row(in_row), .in_attr(in_attr),
      .out_valid(l_out_valid), .out_ready(out_ready), .out_pixels(l_out_pixels),
      .out_oob(l_out_oob), .oob_count(l_oob_count)
   );

   function automatic logic [7:0] model_pix(input logic [7:0] code, input logic [3:0] row,
                                            input logic [2:0] attr);
      int idx;
      logic [7:0] w;
      idx = (code < 27) ? int'(code) : 0;
      w = 8'(idx * 16 + int'(row));
      if (attr[0]) w = ~w;
      if (attr[1] && row == 4'd15) w = 8'hFF;
      if (attr[2]) w = 8'h00;
      return w;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_row = '0; in_attr = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_pixels !== 8'h00 || out_oob !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: got valid=%b pix=%h oob=%b required 0/00/0", out_valid, out_pixels, out_oob);
      end
      checks++;
      if (oob_count !== 8'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_count_ready: got count=%0d ready=%b required 0/1", oob_count, in_ready);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release: got ready=%b valid=%b required 1/0", in_ready, out_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      in_valid = 1'b1; in_code = 8'd3; in_row = 4'd5; in_attr = 3'd0; out_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_early: got valid=%b required 0 one cycle after accept", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pixels !== 8'd53 || out_oob !== 1'b0) begin
         errors++; $display("FAIL basic_data: got valid=%b pix=%0d oob=%b required 1/53/0", out_valid, out_pixels, out_oob);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_nodup: got valid=%b required 0", out_valid);
      end
      $display("test_basic code=3 row=5 pix=%0d", out_pixels);
   endtask

   task automatic test_oob();
      in_valid = 1'b1; in_code = 8'd30; in_row = 4'd2; in_attr = 3'd0;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pixels !== 8'd2 || out_oob !== 1'b1 || oob_count !== 8'd1) begin
         errors++; $display("FAIL oob_first: got valid=%b pix=%0d oob=%b count=%0d required 1/2/1/1", out_valid, out_pixels, out_oob, oob_count);
      end
      in_valid = 1'b1; in_code = 8'd200; in_row = 4'd0;
      repeat (10) @(posedge clk); #1;
      checks++;
      if (oob_count !== 8'd11) begin
         errors++; $display("FAIL oob_count11: got %0d required 11", oob_count);
      end
      repeat (290) @(posedge clk); #1; in_valid = 1'b0;
      checks++;
      if (oob_count !== 8'd255) begin
         errors++; $display("FAIL oob_saturate: got %0d required 255", oob_count);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (oob_count !== 8'd255 || out_valid !== 1'b0) begin
         errors++; $display("FAIL oob_idle: got count=%0d valid=%b required 255/0", oob_count, out_valid);
      end
      $display("test_oob count=%0d", oob_count);
   endtask

   task automatic test_back_to_back();
      logic [7:0] codes [7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd5};
      logic [3:0] rows  [7] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd9};
      logic [2:0] attrs [7] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd5};
      logic [7:0] exps  [7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'h00};
      out_ready = 1'b1;
      for (int cyc = 0; cyc <= 7; cyc++) begin
         if (cyc < 7) begin
            in_valid = 1'b1; in_code = codes[cyc]; in_row = rows[cyc]; in_attr = attrs[cyc];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (cyc >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_pixels !== exps[cyc-1]) begin
               errors++; $display("FAIL b2b_beat%0d: got valid=%b pix=%h required 1/%h", cyc-1, out_valid, out_pixels, exps[cyc-1]);
            end
            $display("test_back_to_back beat %0d pix=%h", cyc-1, out_pixels);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      logic [7:0] exp_pix_q [$];
      logic       exp_oob_q [$];
      logic [7:0] held_pix, ep;
      logic       held_oob, eo, stalled;
      int sent, recv, cyc;
      sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held_pix = '0; held_oob = 1'b0;
      while (recv < 20 && cyc < 400) begin
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_pixels !== held_pix || out_oob !== held_oob) begin
               errors++; $display("FAIL stream_stall_hold: got valid=%b pix=%h required 1/%h", out_valid, out_pixels, held_pix);
            end
            stalled = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (sent < 20) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_code  = 8'((sent * 11 + 3) % 40);
            in_row   = 4'((sent * 5) % 16);
            in_attr  = 3'(sent % 8);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++; $display("FAIL stream_in_ready: got %b required %b", in_ready, !out_valid || out_ready);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_pix_q.size() == 0) begin
               errors++; $display("FAIL stream_extra_beat: got pix=%h required no beat", out_pixels);
            end else begin
               ep = exp_pix_q.pop_front(); eo = exp_oob_q.pop_front();
               if (out_pixels !== ep || out_oob !== eo) begin
                  errors++; $display("FAIL stream_beat%0d: got pix=%h oob=%b required %h/%b", recv, out_pixels, out_oob, ep, eo);
               end
               $display("test_stream beat %0d pix=%h oob=%b", recv, out_pixels, out_oob);
            end
            recv++;
         end
         if (out_valid && !out_ready) begin
            stalled = 1'b1; held_pix = out_pixels; held_oob = out_oob;
         end
         if (in_valid && in_ready) begin
            exp_pix_q.push_back(model_pix(in_code, in_row, in_attr));
            exp_oob_q.push_back(in_code >= 8'd27);
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (recv != 20 || exp_pix_q.size() != 0) begin
         errors++; $display("FAIL stream_complete: got recv=%0d pending=%0d required 20/0", recv, exp_pix_q.size());
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic test_lsb_first();
      in_valid = 1'b1; in_code = 8'd0; in_row = 4'd1; in_attr = 3'd0; out_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (l_out_valid !== 1'b1 || l_out_pixels !== 8'b1000_0000) begin
         errors++; $display("FAIL lsb_first: got valid=%b pix=%b required 1/10000000", l_out_valid, l_out_pixels);
      end
      checks++;
      if (out_pixels !== 8'b0000_0001) begin
         errors++; $display("FAIL msb_first: got pix=%b required 00000001", out_pixels);
      end
      $display("test_lsb_first lsb=%b msb=%b", l_out_pixels, out_pixels);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      in_valid = 1'b1; in_code = 8'd30; in_row = 4'd0; in_attr = 3'd0;
      @(posedge clk); #1;
      in_code = 8'd5; in_row = 4'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || oob_count !== 8'd0 || out_pixels !== 8'h00 || in_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_async: got valid=%b count=%0d pix=%h ready=%b required 0/0/00/1", out_valid, oob_count, out_pixels, in_ready);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL midreset_dropped: got valid=%b required 0", out_valid);
      end
      in_valid = 1'b1; in_code = 8'd2; in_row = 4'd7; in_attr = 3'd0;
      @(posedge clk); #1; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL midreset_early: got valid=%b required 0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pixels !== 8'd39 || out_oob !== 1'b0 || oob_count !== 8'd0) begin
         errors++; $display("FAIL midreset_recover: got valid=%b pix=%0d oob=%b count=%0d required 1/39/0/0", out_valid, out_pixels, out_oob, oob_count);
      end
      $display("test_reset_midstream pix=%0d count=%0d", out_pixels, oob_count);
   endtask

   initial begin
      for (int k = 0; k < 27 * 16; k++) begin
         dut.rom[k]   = 8'(k);
         dut_l.rom[k] = 8'(k);
      end
      test_reset();
      test_basic();
      test_oob();
      test_back_to_back();
      test_stream();
      test_lsb_first();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
